bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   Sits between the CPU register bus (regA value) and the 7-segment decoder;
//   outputs hundreds/tens/units digits, held stable between conversions so
//   the display never sees intermediate values.
//   Optional AUTO mode re-converts whenever the input value changes.
// PARAMETERS
//   WIDTH   8   binary input width; DIGITS must satisfy 10^DIGITS > 2^WIDTH-1
//   DIGITS  3   number of BCD digits produced
//   AUTO    0   1 = self-start on input change; 0 = convert only on start
// PORTS
//   clk_in    in   1          system clock, all logic on rising edge
//   rst_n     in   1          asynchronous active-low reset
//   data_in   in   WIDTH      binary value to convert
//   start     in   1          request conversion; sampled in IDLE only
//   busy      out  1          high while a conversion is in progress
//   done      out  1          one-cycle pulse when bcd_out is updated
//   bcd_out   out  4*DIGITS   packed BCD, [3:0]=units, [7:4]=tens, [11:8]=hundreds
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, busy=0, done=0, bcd_out=0,
//     shift register and bit counter cleared, last-converted value=0.
//   States: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: trigger = start (AUTO=0) or start | (data_in != last_value) (AUTO=1).
//     On trigger: latch data_in into bin_reg and last_value, clear BCD scratch,
//     count=0, go SHIFT. busy=1 from the next cycle.
//   SHIFT (exactly WIDTH cycles): each cycle, for every scratch digit >= 5 add 3,
//     then shift {scratch, bin_reg} left by 1; count++. After count reaches
//     WIDTH go DONE.
//   DONE (1 cycle): bcd_out <= scratch; done=1; busy=0 in this cycle; next IDLE.
//   Latency: start sampled at edge N -> done high during cycle N+WIDTH+1;
//     bcd_out valid from that same cycle and held until the next DONE.
//   start while busy or in DONE: ignored, not queued.
//   data_in may change during SHIFT: no effect on running conversion (latched).
//     With AUTO=1 the new value triggers a fresh conversion on return to IDLE.
//   start and AUTO change-detect in the same cycle: single conversion.
//   Reset mid-conversion: abort immediately, bcd_out returns to 0, no done.
//   done and busy never high together; done never pulses on two adjacent cycles.
//   Max value 2^WIDTH-1 (255 for defaults) must convert without digit overflow.
//   Add-3 correction uses 4-bit per-digit compare; no digit ever exceeds 9 in
//   bcd_out.
// TESTING
//   1 Reset, data_in=0, start 1 cycle -> done after 9 cycles, bcd_out=12'h000.
//   2 data_in=255, start -> bcd_out=12'h255; data_in=99 -> 12'h099;
//     data_in=100 -> 12'h100; data_in=9 -> 12'h009.
//   3 start at N with data_in=42, pulse start again at N+3, change data_in=7
//     at N+4 -> exactly one done at N+9, bcd_out=12'h042.
//   4 Conversion of 200 running, assert rst_n=0 at cycle N+4 -> busy=0,
//     bcd_out=0 immediately, no done pulse; after release start with 17
//     -> 12'h017.
//   5 AUTO=1: data_in steps 5 -> 6 -> 6 -> 250 with start held 0 -> three done
//     pulses, bcd_out sequence 12'h005, 12'h006, 12'h250; no pulse for the
//     repeated 6.
//   6 Exhaustive sweep 0..255 (AUTO=0) -> every result matches reference
//     decimal model; busy/done mutually exclusive throughout.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Brief    : Sequential shift-and-add-3 binary-to-BCD converter, one bit per
//            clock, with held outputs and optional auto-start on input change.
// Revision : 1.0  initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int AUTO   = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      data_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int c_CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_bin;
    logic [WIDTH-1:0]    r_last;
    logic [4*DIGITS-1:0] r_scratch;
    logic [4*DIGITS-1:0] r_bcd;
    logic [4*DIGITS-1:0] w_adj;
    logic [4*DIGITS-1:0] w_scratch_nxt;
    logic [c_CW-1:0]     r_count;
    logic                w_change;
    logic                w_trigger;
    logic                w_last_shift;

    assign w_change     = (data_in != r_last);
    assign w_trigger    = start | ((AUTO != 0) & w_change);
    assign w_last_shift = (r_count == c_CW'(WIDTH - 1));

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign w_adj[4*d +: 4] = (r_scratch[4*d +: 4] >= 4'd5) ?
                                 r_scratch[4*d +: 4] + 4'd3 :
                                 r_scratch[4*d +: 4];
    end

    assign w_scratch_nxt = {w_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_trigger)    w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last_shift) w_state_nxt = S_DONE;
            S_DONE:                    w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    // bcd_out is loaded on the final shift so it is already valid while done is high.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_bin     <= '0;
            r_last    <= '0;
            r_scratch <= '0;
            r_bcd     <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_bin     <= data_in;
                        r_last    <= data_in;
                        r_scratch <= '0;
                        r_count   <= '0;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_scratch_nxt;
                    r_bin     <= {r_bin[WIDTH-2:0], 1'b0};
                    r_count   <= r_count + c_CW'(1);
                    if (w_last_shift) begin
                        r_bcd <= w_scratch_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (r_state == S_SHIFT);
    assign done    = (r_state == S_DONE);
    assign bcd_out = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_seq
// Brief    : Self-checking bench for bin_to_bcd_seq (manual and auto modes).
// Revision : 1.0  initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    localparam int c_W = 8;
    localparam int c_D = 3;

    logic              clk_in = 1'b0;
    logic              rst_n  = 1'b0;
    logic [c_W-1:0]    m_data = '0;
    logic              m_start = 1'b0;
    logic              m_busy, m_done;
    logic [4*c_D-1:0]  m_bcd;
    logic [c_W-1:0]    a_data = '0;
    logic              a_start = 1'b0;
    logic              a_busy, a_done;
    logic [4*c_D-1:0]  a_bcd;

    int errors = 0;
    int checks = 0;
    logic m_prev_done = 1'b0;
    logic a_prev_done = 1'b0;

    always #5 clk_in = ~clk_in;

    bin_to_bcd_seq #(.WIDTH(c_W), .DIGITS(c_D), .AUTO(0)) u_dut (
        .clk_in(clk_in), .rst_n(rst_n), .data_in(m_data), .start(m_start),
        .busy(m_busy), .done(m_done), .bcd_out(m_bcd)
    );

    bin_to_bcd_seq #(.WIDTH(c_W), .DIGITS(c_D), .AUTO(1)) u_auto (
        .clk_in(clk_in), .rst_n(rst_n), .data_in(a_data), .start(a_start),
        .busy(a_busy), .done(a_done), .bcd_out(a_bcd)
    );

    typedef struct {
        logic [c_W-1:0]   din;
        logic [4*c_D-1:0] exp;
    } vec_t;

    // Decimal digits by plain division, independent of the shift algorithm.
    function automatic logic [4*c_D-1:0] ref_bcd(input int unsigned v);
        logic [4*c_D-1:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < c_D; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk_in) begin
        checks++;
        if ((m_busy && m_done) || (m_done && m_prev_done) ||
            (a_busy && a_done) || (a_done && a_prev_done)) begin
            errors++;
            $display("FAIL handshake: busy/done m=%b%b a=%b%b prev_done m=%b a=%b",
                     m_busy, m_done, a_busy, a_done, m_prev_done, a_prev_done);
        end
        m_prev_done = m_done;
        a_prev_done = a_done;
    end

    task automatic convert(input logic [c_W-1:0] v, output logic [4*c_D-1:0] got, output int lat);
        @(negedge clk_in);
        m_data  = v;
        m_start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk_in);
            m_start = 1'b0;
            lat++;
        end while (!m_done && lat < 40);
        got = m_bcd;
    endtask

    task automatic wait_auto(output logic [4*c_D-1:0] got, output int lat);
        lat = 0;
        do begin
            @(negedge clk_in);
            lat++;
        end while (!a_done && lat < 40);
        got = a_bcd;
    endtask

    initial begin
        vec_t vecs[8];
        logic [4*c_D-1:0] got;
        int lat;
        int ndone;
        int first_k;
        logic [c_W-1:0] rv;

        vecs[0] = '{8'd0,   12'h000};
        vecs[1] = '{8'd255, 12'h255};
        vecs[2] = '{8'd99,  12'h099};
        vecs[3] = '{8'd100, 12'h100};
        vecs[4] = '{8'd9,   12'h009};
        vecs[5] = '{8'd1,   12'h001};
        vecs[6] = '{8'd128, 12'h128};
        vecs[7] = '{8'd42,  12'h042};

        repeat (3) @(negedge clk_in);
        check("reset_busy", 32'(m_busy), 32'd0);
        check("reset_done", 32'(m_done), 32'd0);
        check("reset_bcd",  32'(m_bcd),  32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);
        check("auto_idle_after_reset", 32'(a_busy), 32'd0);

        foreach (vecs[i]) begin
            convert(vecs[i].din, got, lat);
            check($sformatf("vec%0d_bcd", i), 32'(got), 32'(vecs[i].exp));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(c_W + 1));
        end

        // Extra start mid-conversion and in DONE, input change mid-run.
        @(negedge clk_in);
        m_data  = 8'd42;
        m_start = 1'b1;
        ndone   = 0;
        first_k = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_in);
            m_start = (k == 3) || (k == 9);
            if (k == 4) m_data = 8'd7;
            if (m_done) begin
                ndone++;
                if (first_k < 0) first_k = k;
                check("ign_bcd_at_done", 32'(m_bcd), 32'h042);
            end
        end
        m_start = 1'b0;
        check("ign_done_count", 32'(ndone), 32'd1);
        check("ign_done_cycle", 32'(first_k), 32'd9);
        check("ign_bcd_held", 32'(m_bcd), 32'h042);

        // Reset mid-conversion.
        @(negedge clk_in);
        m_data  = 8'd200;
        m_start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_in);
            m_start = 1'b0;
        end
        check("midrst_busy_before", 32'(m_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(m_busy), 32'd0);
        check("midrst_bcd",  32'(m_bcd),  32'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            if (m_done) ndone++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            if (m_done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        convert(8'd17, got, lat);
        check("midrst_after_bcd", 32'(got), 32'h017);

        // AUTO mode: change-triggered conversions, none for a repeated value.
        ndone = 0;
        @(negedge clk_in);
        a_data = 8'd5;
        wait_auto(got, lat);
        if (a_done) ndone++;
        check("auto_5_bcd", 32'(got), 32'h005);
        check("auto_5_lat", 32'(lat), 32'(c_W + 1));
        @(negedge clk_in);
        a_data = 8'd6;
        wait_auto(got, lat);
        if (a_done) ndone++;
        check("auto_6_bcd", 32'(got), 32'h006);
        @(negedge clk_in);
        a_data = 8'd6;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk_in);
            if (a_done) ndone++;
        end
        a_data = 8'd250;
        wait_auto(got, lat);
        if (a_done) ndone++;
        check("auto_250_bcd", 32'(got), 32'h250);
        check("auto_done_count", 32'(ndone), 32'd3);

        // Exhaustive sweep against the decimal model.
        for (int v = 0; v < 256; v++) begin
            convert(8'(v), got, lat);
            check($sformatf("sweep_%0d", v), 32'(got), 32'(ref_bcd(v)));
        end

        // Random values with random idle gaps.
        for (int n = 0; n < 40; n++) begin
            rv = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(negedge clk_in);
            convert(rv, got, lat);
            check($sformatf("rand_%0d", rv), 32'(got), 32'(ref_bcd(32'(rv))));
            check("rand_lat", 32'(lat), 32'(c_W + 1));
        end

        repeat (3) @(negedge clk_in);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
